// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Shared definitions for the restoring-division controller:
//               state encoding and default operand width.
// Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    localparam int DEFAULT_WIDTH = 64;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_SUB   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = S_IDLE,
        ST_INIT  = S_INIT,
        ST_SHIFT = S_SHIFT,
        ST_SUB   = S_SUB,
        ST_DONE  = S_DONE
    } state_t;

endpackage
`default_nettype wire

// File: rtl/div_if.sv
`default_nettype none
// ============================================================================
// Module      : div_if
// Description : Handshake and datapath-strobe bundle between the division
//               controller and its user/datapath.
// Revision    : 1.0 - initial release
// ============================================================================
interface div_if #(
    parameter int CW = 6
);
    logic          START;
    logic          ABORT;
    logic          NEG;
    logic          DVSR_ZERO;
    logic          INIT;
    logic          SH;
    logic          LDA;
    logic          Q_BIT;
    logic          BUSY;
    logic          DONE;
    logic          ERR;
    logic [CW-1:0] CNT;

    // Requester/datapath side
    modport master (
        output START, ABORT, NEG, DVSR_ZERO,
        input  INIT, SH, LDA, Q_BIT, BUSY, DONE, ERR, CNT
    );

    // Controller side
    modport slave (
        input  START, ABORT, NEG, DVSR_ZERO,
        output INIT, SH, LDA, Q_BIT, BUSY, DONE, ERR, CNT
    );
endinterface
`default_nettype wire

// File: rtl/div_iter_cnt.sv
`default_nettype none
// ============================================================================
// Module      : div_iter_cnt
// Description : Iteration counter for the shift/subtract loop with clear,
//               enable and terminal-count (last iteration) flag.
// Revision    : 1.0 - initial release
// ============================================================================
module div_iter_cnt #(
    parameter int WIDTH = 64,
    parameter int CW    = $clog2(WIDTH)
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          i_clr,
    input  wire logic          i_en,
    output logic      [CW-1:0] o_cnt,
    output logic               o_tc
);
    localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

    logic [CW-1:0] r_cnt;

    // Count iterations; clear has priority so a restart always begins at 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : div_ctrl
// Description : Sequencing FSM for a restoring divider. One START produces an
//               INIT strobe, WIDTH shift/subtract iterations and a DONE pulse.
//               Strobes change on posedge and are consumed by the datapath on
//               negedge, so each is stable for its whole cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module div_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CW    = $clog2(WIDTH)
) (
    input  wire logic clk,
    input  wire logic rst,
    div_if.slave      bus
);
    state_t        r_state;
    state_t        w_next;
    logic          r_init;
    logic          r_sh;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic          w_abort;
    logic          w_start;
    logic          w_tc;
    logic          w_cnt_clr;
    logic          w_cnt_en;
    logic          w_lda;
    logic [CW-1:0] w_cnt;

    // ABORT only acts while a division is actually running
    assign w_abort = bus.ABORT && ((r_state == ST_INIT) ||
                                   (r_state == ST_SHIFT) ||
                                   (r_state == ST_SUB));
    assign w_start = (r_state == ST_IDLE) && bus.START;

    assign w_cnt_clr = w_start || w_abort;
    assign w_cnt_en  = (r_state == ST_SUB) && !w_tc && !w_abort;

    div_iter_cnt #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_iter_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_cnt_clr),
        .i_en  (w_cnt_en),
        .o_cnt (w_cnt),
        .o_tc  (w_tc)
    );

    // Next-state selection; abort overrides every other transition
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (bus.START) w_next = ST_INIT;
            ST_INIT:  w_next = bus.DVSR_ZERO ? ST_DONE : ST_SHIFT;
            ST_SHIFT: w_next = ST_SUB;
            ST_SUB:   w_next = w_tc ? ST_DONE : ST_SHIFT;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
        if (w_abort) begin
            w_next = ST_IDLE;
        end
    end

    // State register with strobes registered from the upcoming state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_init  <= 1'b0;
            r_sh    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_init  <= (w_next == ST_INIT);
            r_sh    <= (w_next == ST_SHIFT);
            r_busy  <= (w_next != ST_IDLE);
            r_done  <= (w_next == ST_DONE);
            if (w_start) begin
                r_err <= 1'b0;
            end else if ((r_state == ST_INIT) && bus.DVSR_ZERO && !w_abort) begin
                r_err <= 1'b1;
            end
        end
    end

    // NEG is settled for the whole SUB cycle, so the load decision is decoded live
    assign w_lda = (r_state == ST_SUB) && !bus.NEG;

    assign bus.INIT  = r_init;
    assign bus.SH    = r_sh;
    assign bus.LDA   = w_lda;
    assign bus.Q_BIT = w_lda;
    assign bus.BUSY  = r_busy;
    assign bus.DONE  = r_done;
    assign bus.ERR   = r_err;
    assign bus.CNT   = w_cnt;

endmodule
`default_nettype wire

// File: tb/tb_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_ctrl
// Description : Directed self-checking bench for div_ctrl (WIDTH=64 sequencing
//               and a WIDTH=4 instance driving a behavioural datapath).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_ctrl;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    div_if #(.CW(6)) bus  ();
    div_if #(.CW(2)) bus4 ();

    div_ctrl #(.WIDTH(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    div_ctrl #(.WIDTH(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 4-bit restoring-division datapath, strobes taken on negedge
    logic [3:0] m_dividend;
    logic [3:0] m_divisor;
    logic [4:0] m_a;
    logic [3:0] m_dv;
    logic [5:0] w_diff;

    assign w_diff         = {1'b0, m_a} - {2'b00, m_divisor};
    assign bus4.NEG       = w_diff[5];
    assign bus4.DVSR_ZERO = (m_divisor == 4'd0);

    always @(negedge clk) begin
        if (bus4.INIT) begin
            m_a  <= 5'd0;
            m_dv <= m_dividend;
        end else if (bus4.SH) begin
            {m_a, m_dv} <= {m_a[3:0], m_dv, 1'b0};
        end else if (bus4.LDA) begin
            m_a     <= w_diff[4:0];
            m_dv[0] <= bus4.Q_BIT;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] strobes();
        return {bus.INIT, bus.SH, bus.LDA, bus.Q_BIT, bus.BUSY, bus.DONE, bus.ERR};
    endfunction

    // Full WIDTH=64 division from IDLE; alt=1 alternates NEG 1,0,1,0 per SUB
    task automatic run_division(input bit alt);
        int         sh_n;
        int         lda_n;
        bit         sub;
        bit         neg;
        logic [6:0] ev;
        logic [5:0] ec;
        sh_n  = 0;
        lda_n = 0;
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        for (int c = 1; c <= 130; c++) begin
            sub = (c >= 3) && (c <= 129) && (c % 2 == 1);
            neg = alt ? (((c - 3) / 2) % 2 == 0) : 1'b1;
            bus.NEG = sub ? neg : 1'b1;
            #1;
            ev = {c == 1, (c >= 2) && (c <= 128) && (c % 2 == 0),
                  sub && !neg, sub && !neg, 1'b1, c == 130, 1'b0};
            if (c <= 1)        ec = 6'd0;
            else if (c == 130) ec = 6'd63;
            else               ec = 6'((c - 2) / 2);
            chk($sformatf("div%0d_c%0d_strobes", alt, c), 64'(strobes()), 64'(ev));
            chk($sformatf("div%0d_c%0d_cnt", alt, c), 64'(bus.CNT), 64'(ec));
            sh_n  += int'(bus.SH);
            lda_n += int'(bus.LDA);
            tick();
        end
        chk($sformatf("div%0d_sh_pulses", alt), 64'(sh_n), 64'd64);
        chk($sformatf("div%0d_lda_pulses", alt), 64'(lda_n), alt ? 64'd32 : 64'd0);
        chk($sformatf("div%0d_idle_after", alt), 64'(strobes()), 64'd0);
    endtask

    initial begin
        logic [5:0] ec;
        rst            = 1'b0;
        bus.START      = 1'b0;
        bus.ABORT      = 1'b0;
        bus.NEG        = 1'b1;
        bus.DVSR_ZERO  = 1'b0;
        bus4.START     = 1'b0;
        bus4.ABORT     = 1'b0;
        m_dividend     = 4'd13;
        m_divisor      = 4'd3;

        // Reset state
        #2;
        chk("reset_strobes", 64'(strobes()), 64'd0);
        chk("reset_cnt", 64'(bus.CNT), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Normal division, NEG held 1, then alternating NEG
        run_division(1'b0);
        run_division(1'b1);

        // Divide by zero: DONE and ERR in cycle 2, ERR held in IDLE
        bus.DVSR_ZERO = 1'b1;
        bus.START     = 1'b1;
        tick();
        bus.START = 1'b0;
        chk("dz_c1", 64'(strobes()), 64'(7'b1000100));
        tick();
        chk("dz_c2", 64'(strobes()), 64'(7'b0000111));
        tick();
        chk("dz_idle1", 64'(strobes()), 64'(7'b0000001));
        tick();
        chk("dz_idle2", 64'(strobes()), 64'(7'b0000001));

        // Next START clears ERR; START held while busy must be ignored
        bus.DVSR_ZERO = 1'b0;
        bus.START     = 1'b1;
        tick();
        chk("dz_restart_c1", 64'(strobes()), 64'(7'b1000100));
        for (int c = 2; c <= 21; c++) begin
            tick();
            ec = 6'((c - 2) / 2);
            chk($sformatf("ab_c%0d_cnt", c), 64'(bus.CNT), 64'(ec));
            chk($sformatf("ab_c%0d_busy", c), 64'(bus.BUSY), 64'd1);
        end

        // ABORT during SHIFT at CNT=10
        tick();
        bus.START = 1'b0;
        bus.ABORT = 1'b1;
        chk("ab_shift_sh", 64'(bus.SH), 64'd1);
        chk("ab_shift_cnt", 64'(bus.CNT), 64'd10);
        tick();
        bus.ABORT = 1'b0;
        chk("ab_idle_strobes", 64'(strobes()), 64'd0);
        chk("ab_idle_cnt", 64'(bus.CNT), 64'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("ab_quiet%0d", c), 64'(strobes()), 64'd0);
        end

        // Asynchronous reset mid-SUB at CNT=17
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
        for (int c = 2; c <= 37; c++) tick();
        bus.NEG = 1'b0;
        #1;
        chk("rst_pre_cnt", 64'(bus.CNT), 64'd17);
        chk("rst_pre_lda", 64'(bus.LDA), 64'd1);
        rst = 1'b0;
        #1;
        chk("rst_mid_strobes", 64'(strobes()), 64'd0);
        chk("rst_mid_cnt", 64'(bus.CNT), 64'd0);
        #1;
        rst     = 1'b1;
        bus.NEG = 1'b1;
        tick();
        run_division(1'b0);

        // WIDTH=4 with datapath model: 13 / 3 = 4 remainder 1, DONE in cycle 10
        bus4.START = 1'b1;
        tick();
        bus4.START = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            chk($sformatf("w4_c%0d_done", c), 64'(bus4.DONE), 64'(c == 10));
            if (c == 10) begin
                chk("w4_quotient", 64'(m_dv), 64'd4);
                chk("w4_remainder", 64'(m_a), 64'd1);
                chk("w4_err", 64'(bus4.ERR), 64'd0);
            end
            tick();
        end
        chk("w4_idle_busy", 64'(bus4.BUSY), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Sequencing FSM for the restoring-division datapath in the Position subsystem: the 2*WIDTH-bit {A,DV} shift register, the subtractor A-divisor and the quotient-bit insertion.
- Runs one full division per START: init pulse, then WIDTH shift/subtract iterations, then a DONE pulse.
- Drives the datapath strobes INIT, SH and LDA.
- Controller state changes on posedge clk. The datapath samples strobes on negedge clk, so every strobe is stable for the whole clock period in which it is asserted.

Parameters:
- WIDTH, 64, dividend/divisor width; number of shift/subtract iterations.
- CW, $clog2(WIDTH), iteration counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- START  in  1  begin a division; sampled only in IDLE.
- ABORT  in  1  synchronous cancel; returns to IDLE without DONE.
- NEG  in  1  sign bit of (A - divisor); 1 means A < divisor.
- DVSR_ZERO  in  1  divisor == 0 flag from the datapath.
- INIT  out  1  clear A and load DV (datapath).
- SH  out  1  shift {A,DV} left by 1 (datapath).
- LDA  out  1  load A with the subtractor result (datapath).
- Q_BIT  out  1  quotient bit written into DV[0]; qualified by LDA.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle completion pulse.
- ERR  out  1  divide-by-zero flag; held until the next accepted START.
- CNT  out  CW  current iteration index.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, CNT=0. INIT, SH, LDA, Q_BIT, BUSY, DONE and ERR are all 0.
- States: IDLE, INIT, SHIFT, SUB, DONE. Strobe outputs are decoded from the state; LDA and Q_BIT also depend on NEG.
- IDLE: all strobes 0.
  - START=1 -> INIT; clear ERR and CNT.
- INIT: INIT=1, BUSY=1.
  - DVSR_ZERO=1 -> DONE with ERR set to 1.
  - Otherwise -> SHIFT.
- SHIFT: SH=1, BUSY=1. Next state is SUB.
- SUB: BUSY=1; LDA = Q_BIT = ~NEG.
  - NEG reflects A after the preceding negedge shift and is stable for the whole cycle.
  - If CNT==WIDTH-1 -> DONE; else CNT <= CNT+1 -> SHIFT.
- DONE: DONE=1, BUSY=1, all strobes 0. Next state is IDLE. ERR keeps its value.
- Latency: START sampled at edge 0. DONE is high during cycle 2*WIDTH+2, i.e. cycle 130 for WIDTH=64.
  - For the divide-by-zero path, DONE is high during cycle 2.
- At most one of INIT, SH, LDA is high in any cycle.
- START outside IDLE is ignored; no queuing.
- START in the DONE cycle is ignored. A new division needs START in IDLE, so back-to-back throughput is 2*WIDTH+3 cycles.
- ABORT=1 in INIT, SHIFT or SUB -> IDLE next edge, CNT=0, no DONE, ERR unchanged.
  - ABORT has priority over all other transitions.
  - ABORT in IDLE or DONE has no effect.
- rst asserted mid-operation forces the reset values immediately; the datapath contents are then undefined until the next INIT.
- CNT wraps only through the explicit clear; it never exceeds WIDTH-1.

Decomposition:
- Shared package div_pkg:
  - state encoding (localparams S_IDLE, S_INIT, S_SHIFT, S_SUB, S_DONE; 3-bit);
  - default WIDTH=64.
- One sub-module is natural: div_iter_cnt.
  - CW-bit counter with clear, enable and terminal-count output (tc = CNT==WIDTH-1).
  - Async active-low reset.

Test Plan:
- Reset: rst=0 mid-SUB at CNT=17 -> all outputs 0 immediately, CNT=0. After release, START runs a full division normally.
- Normal division, WIDTH=64, NEG held 1: START at edge 0 -> INIT high in cycle 1 only. SH pulses 64 times (cycles 2,4,...,128), LDA never. DONE high in cycle 130 only, ERR=0.
- NEG alternating per SUB (1,0,1,0...) -> LDA/Q_BIT high in every second SUB cycle (32 pulses total), always one cycle after an SH pulse, never coincident with SH.
- Divide by zero: DVSR_ZERO=1, START -> INIT in cycle 1, DONE and ERR=1 in cycle 2, no SH. ERR stays 1 in IDLE and clears on the next START.
- ABORT during SHIFT at CNT=10 -> IDLE on the next edge, BUSY=0, no DONE. START asserted during BUSY is ignored, with CNT sequence unchanged.
- Small-parameter check, WIDTH=4: dividend 13, divisor 3 with a datapath model -> DONE in cycle 10, quotient 4, remainder 1.
